// File: rtl/usb_cmd_frame_parser_if.sv
// Byte-stream input and command-handler bus of the USB command frame parser.
// The parser uses the master modport; a handler or bench uses the slave modport.
interface usb_cmd_frame_parser_if;
   logic [7:0]  usb_data_in;
   logic        usb_data_valid_in;
   logic [7:0]  cmd_type;
   logic [15:0] cmd_length;
   logic        cmd_start;
   logic [7:0]  cmd_data;
   logic [15:0] cmd_data_index;
   logic        cmd_data_valid;
   logic        cmd_data_ready;
   logic        cmd_done;
   logic        parse_error;
   logic        overrun;
   logic        busy;

   modport master (
      input  usb_data_in, usb_data_valid_in, cmd_data_ready,
      output cmd_type, cmd_length, cmd_start, cmd_data, cmd_data_index,
             cmd_data_valid, cmd_done, parse_error, overrun, busy
   );

   modport slave (
      output usb_data_in, usb_data_valid_in, cmd_data_ready,
      input  cmd_type, cmd_length, cmd_start, cmd_data, cmd_data_index,
             cmd_data_valid, cmd_done, parse_error, overrun, busy
   );
endinterface

// File: rtl/usb_cmd_frame_parser.sv
// Parses AA 55 CMD LEN_H LEN_L PAYLOAD CHK frames, buffers and checks them,
// then replays the payload to command handlers over a valid/ready handshake.
module usb_cmd_frame_parser #(
   parameter int MAX_PAYLOAD    = 256,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic                    clk,
   input logic                    rst_n,
   usb_cmd_frame_parser_if.master bus
);
   localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [15:0]   MAX_LEN = 16'(MAX_PAYLOAD);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_SYNC, S_CMD, S_LEN_H, S_LEN_L, S_DATA, S_CHK, S_DISPATCH, S_DONE
   } state_t;

   state_t          state_q;
   logic [7:0]      sum_q;
   logic [7:0]      cmd_type_q;
   logic [7:0]      len_h_q;
   logic [15:0]     len_q;
   logic [15:0]     wr_idx_q;
   logic [15:0]     idx_q;
   logic [TW-1:0]   to_cnt_q;
   logic            start_q;
   logic            done_q;
   logic            err_q;
   logic            ovr_q;
   logic            vld_q;
   logic [7:0]      rd_data_q;
   logic [7:0]      mem [MAX_PAYLOAD];

   logic            strobe;
   logic [7:0]      byte_in;
   logic [7:0]      sum_d;
   logic [15:0]     len_d;
   logic            in_frame;
   logic            xfer;
   logic            last_xfer;
   logic            wr_en;
   logic            rd_en;
   logic [AW-1:0]   rd_addr;

   assign strobe    = bus.usb_data_valid_in;
   assign byte_in   = bus.usb_data_in;
   assign sum_d     = sum_q + byte_in;
   assign len_d     = {len_h_q, byte_in};
   assign in_frame  = state_q inside {S_SYNC, S_CMD, S_LEN_H, S_LEN_L, S_DATA, S_CHK};
   assign xfer      = vld_q && bus.cmd_data_ready;
   assign last_xfer = xfer && (idx_q == len_q - 16'd1);
   assign wr_en     = (state_q == S_DATA) && strobe;

   // Read ahead: byte 0 is fetched while cmd_start is high, byte i+1 on the transfer of byte i.
   assign rd_en   = (state_q == S_DISPATCH) &&
                    ((start_q && (len_q != 16'd0)) || (xfer && !last_xfer));
   assign rd_addr = start_q ? '0 : AW'(idx_q + 16'd1);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx_q[AW-1:0]] <= byte_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data_q <= '0;
      else if (rd_en) rd_data_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sum_q      <= '0;
         cmd_type_q <= '0;
         len_h_q    <= '0;
         len_q      <= '0;
         wr_idx_q   <= '0;
         idx_q      <= '0;
         to_cnt_q   <= '0;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
         vld_q      <= 1'b0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (strobe && byte_in == 8'hAA) state_q <= S_SYNC;
            end
            S_SYNC: begin
               if (strobe) begin
                  if (byte_in == 8'h55) begin
                     sum_q   <= '0;
                     state_q <= S_CMD;
                  end else if (byte_in != 8'hAA) begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_CMD: begin
               if (strobe) begin
                  cmd_type_q <= byte_in;
                  sum_q      <= sum_d;
                  state_q    <= S_LEN_H;
               end
            end
            S_LEN_H: begin
               if (strobe) begin
                  len_h_q <= byte_in;
                  sum_q   <= sum_d;
                  state_q <= S_LEN_L;
               end
            end
            S_LEN_L: begin
               if (strobe) begin
                  len_q    <= len_d;
                  sum_q    <= sum_d;
                  wr_idx_q <= '0;
                  if (len_d > MAX_LEN) begin
                     err_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end else if (len_d == 16'd0) begin
                     state_q <= S_CHK;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (strobe) begin
                  sum_q    <= sum_d;
                  wr_idx_q <= wr_idx_q + 16'd1;
                  if (wr_idx_q == len_q - 16'd1) state_q <= S_CHK;
               end
            end
            S_CHK: begin
               if (strobe) begin
                  if (byte_in == sum_q) begin
                     start_q <= 1'b1;
                     idx_q   <= '0;
                     state_q <= S_DISPATCH;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_DISPATCH: begin
               if (strobe) ovr_q <= 1'b1;
               if (start_q) begin
                  if (len_q == 16'd0) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     vld_q <= 1'b1;
                     idx_q <= '0;
                  end
               end else if (last_xfer) begin
                  vld_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (xfer) begin
                  idx_q <= idx_q + 16'd1;
               end
            end
            S_DONE: begin
               if (strobe) ovr_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // A strobe always restarts the inter-byte timer, even on the expiry cycle.
         if (in_frame) begin
            if (strobe) begin
               to_cnt_q <= '0;
            end else if (to_cnt_q == TO_LAST) begin
               to_cnt_q <= '0;
               err_q    <= 1'b1;
               state_q  <= S_IDLE;
            end else begin
               to_cnt_q <= to_cnt_q + 1'b1;
            end
         end else begin
            to_cnt_q <= '0;
         end
      end
   end

   assign bus.cmd_type       = cmd_type_q;
   assign bus.cmd_length     = len_q;
   assign bus.cmd_start      = start_q;
   assign bus.cmd_data       = rd_data_q;
   assign bus.cmd_data_index = idx_q;
   assign bus.cmd_data_valid = vld_q;
   assign bus.cmd_done       = done_q;
   assign bus.parse_error    = err_q;
   assign bus.overrun        = ovr_q;
   assign bus.busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Directed bench for usb_cmd_frame_parser: expected commands and payload bytes
// are queued as frames are sent and checked as the parser replays them.
module tb_usb_cmd_frame_parser;
   localparam int TO = 200;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   usb_cmd_frame_parser_if bus();

   usb_cmd_frame_parser #(.MAX_PAYLOAD(256), .TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   typedef logic [7:0] bq_t[$];

   int n_checks = 0;
   int n_fail   = 0;
   int n_start  = 0;
   int n_done   = 0;
   int n_err    = 0;
   int n_ovr    = 0;
   int cyc      = 0;
   logic [23:0] exp_cmd_q[$];
   logic [23:0] exp_dat_q[$];
   bq_t seq;

   int         rdy_mode = 0;
   int         tog_k    = 0;
   logic [3:0] tog_pat  = 4'b1001;

   logic [7:0]  cur_type;
   logic [15:0] cur_len;
   int          nx = 0;
   int          last_evt = 0;
   logic        stall_prev = 1'b0;
   logic [7:0]  prev_data;
   logic [15:0] prev_idx;
   logic [23:0] e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_cmd(input logic [7:0] t, input logic [15:0] l);
      exp_cmd_q.push_back({t, l});
   endtask

   task automatic push_dat(input logic [15:0] i, input logic [7:0] d);
      exp_dat_q.push_back({i, d});
   endtask

   // Called at posedge+1; each byte is sampled at the following posedge.
   task automatic send_seq(input bq_t s);
      foreach (s[i]) begin
         bus.usb_data_in       = s[i];
         bus.usb_data_valid_in = 1'b1;
         @(posedge clk); #1;
      end
      bus.usb_data_valid_in = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int k = 0;
      while (bus.busy && k < bound) begin
         @(posedge clk); #1;
         k++;
      end
      chk("wait_idle", 32'(bus.busy), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int bound);
      int k = 0;
      while (!bus.cmd_done && k < bound) begin
         @(posedge clk); #1;
         k++;
      end
      chk("wait_done", 32'(bus.cmd_done), 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_valid(input int bound);
      int k = 0;
      while (!bus.cmd_data_valid && k < bound) begin
         @(posedge clk); #1;
         k++;
      end
      chk("wait_valid", 32'(bus.cmd_data_valid), 1);
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1: begin
            bus.cmd_data_ready = tog_pat[tog_k];
            tog_k = (tog_k + 1) % 4;
         end
         2:       bus.cmd_data_ready = 1'b0;
         default: bus.cmd_data_ready = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (bus.cmd_start) begin
            n_start++;
            chk("start_expected", 32'(exp_cmd_q.size() > 0), 1);
            if (exp_cmd_q.size() > 0) begin
               e = exp_cmd_q.pop_front();
               chk("cmd_type", 32'(bus.cmd_type), 32'(e[23:16]));
               chk("cmd_length", 32'(bus.cmd_length), 32'(e[15:0]));
            end
            cur_type = bus.cmd_type;
            cur_len  = bus.cmd_length;
            nx       = 0;
            last_evt = cyc;
         end
         if (stall_prev) begin
            chk("hold_valid", 32'(bus.cmd_data_valid), 1);
            chk("hold_data", 32'(bus.cmd_data), 32'(prev_data));
            chk("hold_index", 32'(bus.cmd_data_index), 32'(prev_idx));
         end
         stall_prev = bus.cmd_data_valid && !bus.cmd_data_ready;
         prev_data  = bus.cmd_data;
         prev_idx   = bus.cmd_data_index;
         if (bus.cmd_data_valid && bus.cmd_data_ready) begin
            chk("data_expected", 32'(exp_dat_q.size() > 0), 1);
            if (exp_dat_q.size() > 0) begin
               e = exp_dat_q.pop_front();
               chk("data_index", 32'(bus.cmd_data_index), 32'(e[23:8]));
               chk("data_byte", 32'(bus.cmd_data), 32'(e[7:0]));
            end
            nx++;
            last_evt = cyc;
         end
         if (bus.cmd_done) begin
            n_done++;
            chk("done_count", 32'(nx), 32'(cur_len));
            chk("done_latency", 32'(cyc - last_evt), 1);
            chk("type_stable", 32'(bus.cmd_type), 32'(cur_type));
            chk("length_stable", 32'(bus.cmd_length), 32'(cur_len));
         end
         if (bus.parse_error) n_err++;
         if (bus.overrun)     n_ovr++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0, d0, e0, o0;
      rst_n = 1'b0;
      bus.usb_data_in       = 8'h00;
      bus.usb_data_valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_type",   32'(bus.cmd_type), 0);
      chk("rst_cmd_length", 32'(bus.cmd_length), 0);
      chk("rst_cmd_start",  32'(bus.cmd_start), 0);
      chk("rst_cmd_data",   32'(bus.cmd_data), 0);
      chk("rst_cmd_index",  32'(bus.cmd_data_index), 0);
      chk("rst_cmd_valid",  32'(bus.cmd_data_valid), 0);
      chk("rst_cmd_done",   32'(bus.cmd_done), 0);
      chk("rst_parse_err",  32'(bus.parse_error), 0);
      chk("rst_overrun",    32'(bus.overrun), 0);
      chk("rst_busy",       32'(bus.busy), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 3-byte 0x15 command
      s0 = n_start; d0 = n_done; e0 = n_err;
      push_cmd(8'h15, 16'd3);
      push_dat(16'd0, 8'h02); push_dat(16'd1, 8'hAD); push_dat(16'd2, 8'hDE);
      seq = '{8'hAA, 8'h55, 8'h15, 8'h00, 8'h03, 8'h02, 8'hAD, 8'hDE, 8'hA5};
      send_seq(seq);
      wait_idle(50);
      chk("t1_starts", 32'(n_start - s0), 1);
      chk("t1_dones",  32'(n_done - d0), 1);
      chk("t1_errors", 32'(n_err - e0), 0);

      // Back-to-back: second AA arrives the cycle after cmd_done
      s0 = n_start; e0 = n_err;
      push_cmd(8'h14, 16'd1); push_dat(16'd0, 8'h5A);
      seq = '{8'hAA, 8'h55, 8'h14, 8'h00, 8'h01, 8'h5A, 8'h6F};
      send_seq(seq);
      wait_done(50);
      push_cmd(8'h16, 16'd1); push_dat(16'd0, 8'h02);
      seq = '{8'hAA, 8'h55, 8'h16, 8'h00, 8'h01, 8'h02, 8'h19};
      send_seq(seq);
      wait_idle(50);
      chk("b2b_starts", 32'(n_start - s0), 2);
      chk("b2b_errors", 32'(n_err - e0), 0);

      // Bad checksum
      s0 = n_start; e0 = n_err;
      seq = '{8'hAA, 8'h55, 8'h14, 8'h00, 8'h01, 8'h5A, 8'h70};
      send_seq(seq);
      chk("chk_err_pulse", 32'(bus.parse_error), 1);
      wait_idle(50);
      chk("chk_err_count", 32'(n_err - e0), 1);
      chk("chk_no_start",  32'(n_start - s0), 0);
      chk("chk_busy",      32'(bus.busy), 0);

      // Ready toggling 1,0,0,1 plus an injected byte during dispatch
      s0 = n_start; o0 = n_ovr;
      rdy_mode = 1;
      push_cmd(8'h15, 16'd3);
      push_dat(16'd0, 8'h02); push_dat(16'd1, 8'hAD); push_dat(16'd2, 8'hDE);
      seq = '{8'hAA, 8'h55, 8'h15, 8'h00, 8'h03, 8'h02, 8'hAD, 8'hDE, 8'hA5};
      send_seq(seq);
      wait_valid(20);
      seq = '{8'h33};
      send_seq(seq);
      chk("ovr_pulse", 32'(bus.overrun), 1);
      wait_idle(100);
      rdy_mode = 0;
      chk("ovr_count",  32'(n_ovr - o0), 1);
      chk("tog_starts", 32'(n_start - s0), 1);

      // Oversize LEN rejected right after LEN_L, then a good frame
      s0 = n_start; e0 = n_err;
      seq = '{8'hAA, 8'h55, 8'h14, 8'h01, 8'h01};
      send_seq(seq);
      chk("len_err_pulse", 32'(bus.parse_error), 1);
      chk("len_err_busy",  32'(bus.busy), 0);
      push_cmd(8'h14, 16'd1); push_dat(16'd0, 8'h5A);
      seq = '{8'hAA, 8'h55, 8'h14, 8'h00, 8'h01, 8'h5A, 8'h6F};
      send_seq(seq);
      wait_idle(50);
      chk("len_err_count", 32'(n_err - e0), 1);
      chk("len_next_start", 32'(n_start - s0), 1);

      // Inter-byte timeout
      e0 = n_err;
      seq = '{8'hAA, 8'h55, 8'h15, 8'h00, 8'h03, 8'h02};
      send_seq(seq);
      repeat (TO - 5) @(posedge clk);
      #1;
      chk("to_not_yet_busy", 32'(bus.busy), 1);
      chk("to_not_yet_err",  32'(n_err - e0), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("to_err_count", 32'(n_err - e0), 1);
      chk("to_busy",      32'(bus.busy), 0);

      // Byte arriving exactly on the expiry cycle keeps the frame alive
      s0 = n_start; e0 = n_err;
      push_cmd(8'h14, 16'd1); push_dat(16'd0, 8'h5A);
      seq = '{8'hAA, 8'h55, 8'h14, 8'h00};
      send_seq(seq);
      repeat (TO - 1) @(posedge clk);
      #1;
      seq = '{8'h01, 8'h5A, 8'h6F};
      send_seq(seq);
      wait_idle(50);
      chk("edge_to_err",   32'(n_err - e0), 0);
      chk("edge_to_start", 32'(n_start - s0), 1);

      // Zero-length command
      s0 = n_start; d0 = n_done;
      push_cmd(8'h20, 16'd0);
      seq = '{8'hAA, 8'h55, 8'h20, 8'h00, 8'h00, 8'h20};
      send_seq(seq);
      chk("len0_start_pulse", 32'(bus.cmd_start), 1);
      wait_idle(20);
      chk("len0_starts", 32'(n_start - s0), 1);
      chk("len0_dones",  32'(n_done - d0), 1);

      // Reset in the middle of a stalled dispatch
      d0 = n_done;
      rdy_mode = 2;
      push_cmd(8'h15, 16'd3);
      seq = '{8'hAA, 8'h55, 8'h15, 8'h00, 8'h03, 8'h02, 8'hAD, 8'hDE, 8'hA5};
      send_seq(seq);
      wait_valid(20);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.cmd_data_valid), 0);
      chk("mid_rst_busy",  32'(bus.busy), 0);
      chk("mid_rst_data",  32'(bus.cmd_data), 0);
      chk("mid_rst_len",   32'(bus.cmd_length), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdy_mode = 0;
      exp_dat_q.delete();
      repeat (5) @(posedge clk);
      #1;
      chk("mid_rst_no_done", 32'(n_done - d0), 0);

      chk("cmd_queue_empty", 32'(exp_cmd_q.size()), 0);
      chk("dat_queue_empty", 32'(exp_dat_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/usb_cmd_frame_parser.md
Name: usb_cmd_frame_parser

Overview:
- Front-end stage between the USB-CDC byte stream (usb_data_in / usb_data_valid_in) and the command handlers (I2C slave handler cmds 0x14/0x15/0x16, PWM, UART, SPI, …).
- Frame format: AA 55 CMD LEN_H LEN_L PAYLOAD[LEN] CHK; CHK = 8-bit sum of CMD, LEN_H, LEN_L and all payload bytes.
- Buffers the payload, validates the checksum, then replays the payload to handlers with a valid/ready handshake, framed by cmd_start and cmd_done pulses.

Parameters:
- MAX_PAYLOAD, 256: payload buffer depth in bytes; LEN above this is rejected.
- TIMEOUT_CYCLES, 50000: idle clk cycles allowed between bytes inside a frame (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- usb_data_in  in  8  received USB byte.
- usb_data_valid_in  in  1  one-cycle byte strobe; no backpressure.
- cmd_type  out  8  CMD of the current frame; stable from cmd_start through cmd_done.
- cmd_length  out  16  LEN of the current frame; stable from cmd_start through cmd_done.
- cmd_start  out  1  one-cycle pulse: a valid frame has been accepted.
- cmd_data  out  8  payload byte being replayed.
- cmd_data_index  out  16  index of cmd_data, starting at 0.
- cmd_data_valid  out  1  cmd_data is valid.
- cmd_data_ready  in  1  handler accepts cmd_data.
- cmd_done  out  1  one-cycle pulse after the last payload byte is accepted.
- parse_error  out  1  one-cycle pulse on checksum mismatch, oversize LEN or timeout.
- overrun  out  1  one-cycle pulse when an input byte is dropped during dispatch.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; buffer contents don't-care.
- States: IDLE, SYNC, CMD, LEN_H, LEN_L, DATA, CHK, DISPATCH, DONE.
- IDLE: byte AA -> SYNC; any other byte is ignored.
- SYNC: byte 55 -> CMD; byte AA -> stay in SYNC; any other byte -> IDLE, with no error.
- CMD, LEN_H, LEN_L: latch the byte and add it to the running 8-bit sum (mod 256). The sum is cleared on entry to CMD.
- After LEN_L:
  - LEN > MAX_PAYLOAD -> parse_error, IDLE; the rest of the frame is resynced through IDLE.
  - LEN = 0 -> CHK.
  - Otherwise -> DATA.
- DATA: each byte is written to buffer[wr_idx] and added to the sum; after byte LEN-1 -> CHK.
- CHK on the received byte:
  - equal to sum -> DISPATCH; cmd_start asserted in the cycle after the CHK strobe.
  - not equal -> parse_error in the cycle after the strobe; IDLE; no cmd_start.
- DISPATCH:
  - First cmd_data_valid is no earlier than the cycle after cmd_start.
  - Buffer read is synchronous (one cycle). cmd_data and cmd_data_index hold while valid is high and ready is low.
  - Transfer occurs when valid and ready are both high; the next byte may be valid in the next cycle. Full throughput (1 byte/clk) is required when ready is held high.
  - After the transfer of index LEN-1: valid drops, cmd_done pulses next cycle -> IDLE.
  - LEN = 0: cmd_done pulses the cycle after cmd_start.
- Inter-byte timeout: the counter clears on every strobe. In states SYNC through CHK, TIMEOUT_CYCLES cycles without a strobe -> parse_error, IDLE.
- Overrun: a strobe during DISPATCH or DONE is dropped, pulses overrun, and the state is unchanged.
- Strobe in the same cycle as the timeout expiry: the byte wins and the counter is cleared.
- Reset asserted mid-frame or mid-dispatch: immediate return to IDLE with all outputs 0; no cmd_done is issued.
- Back-to-back frames: an AA arriving the cycle after cmd_done is parsed normally.

Test Plan:
- Frame AA 55 15 00 03 02 AD DE A5 -> one cmd_start with cmd_type=15, cmd_length=3; bytes 02, AD, DE at indices 0, 1, 2; cmd_done; no parse_error.
- Frame AA 55 14 00 01 5A 6F, then immediately AA 55 16 00 01 02 19 -> two commands in order: (14, [5A]) then (16, [02]).
- Frame AA 55 14 00 01 5A 70 -> parse_error once; no cmd_start; busy returns to 0.
- cmd_data_ready toggling 1,0,0,1,… on the 0x15 frame -> each byte held stable while stalled; 3 transfers total; overrun pulses when an extra byte is injected during dispatch.
- LEN=0x0101 (MAX_PAYLOAD=256) -> parse_error right after LEN_L; a following valid 0x14 frame is still accepted.
- Stimulus: AA 55 15 00 03 02, then silence for TIMEOUT_CYCLES -> parse_error. Also: frame 0x20 with LEN=0 and CHK 20 -> cmd_start, then cmd_done the next cycle.
